nx_indirect_access_initiator: RTL and testbench

- Hardware-side master for the indirect memory access register protocol.
- Accepts one table operation at a time (op, address, write data) over valid/ready and drives the command interface of a TCAM/SRAM indirect-access responder.
- Tracks the responder's status code until the command completes, then returns completion status and read data over a valid/ready response channel.
- Used by table-load and self-test engines that must program TCAM entries without firmware.

---
 rtl/nx_mem_typePKG.sv | 45 ++++
 rtl/nx_indirect_poll_timer.sv | 30 +++
 rtl/nx_indirect_access_initiator.sv | 171 +++++++++++++++++
 tb/tb_nx_indirect_access_initiator.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nx_mem_typePKG.sv
// Shared encodings for the indirect memory access protocol, plus the
// state type used by the hardware-side initiator.
package nx_mem_typePKG;

  typedef enum logic [3:0] {
    OP_NOP            = 4'd0,
    OP_READ           = 4'd1,
    OP_WRITE          = 4'd2,
    OP_ENABLE         = 4'd3,
    OP_DISABLE        = 4'd4,
    OP_RESET          = 4'd5,
    OP_INIT           = 4'd6,
    OP_INIT_INC       = 4'd7,
    OP_SET_INIT_START = 4'd8,
    OP_COMPARE        = 4'd9,
    OP_SIM_TMO        = 4'd14,
    OP_ACK_ERROR      = 4'd15
  } cmnd_op_t;

  typedef enum logic [2:0] {
    ST_EMPTY     = 3'd0,
    ST_OK        = 3'd1,
    ST_KEY_ERROR = 3'd2,
    ST_TIMEOUT   = 3'd4,
    ST_NAK       = 3'd5,
    ST_BUSY      = 3'd7
  } stat_code_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_POLL,
    S_RESP,
    S_ACK,
    S_SETTLE_ACK,
    S_ACK_POLL
  } initiator_state_t;

  // A command has finished once the responder shows anything but BUSY or EMPTY.
  function automatic logic stat_is_done(input logic [2:0] code);
    return (code != ST_BUSY) && (code != ST_EMPTY);
  endfunction

endpackage

// File: rtl/nx_indirect_poll_timer.sv
// Saturating poll-wait counter; expired stays high once the last count is
// reached until the next clear.
module nx_indirect_poll_timer #(
  parameter int TMO_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TMO_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TMO_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/nx_indirect_access_initiator.sv
// Hardware master for the indirect access register protocol: issues one
// table command, polls the responder status, returns status and read data.
module nx_indirect_access_initiator
  import nx_mem_typePKG::*;
#(
  parameter int                         N_REG_ADDR_BITS = 16,
  parameter logic [N_REG_ADDR_BITS-1:0] CMND_ADDRESS    = '0,
  parameter int                         N_DATA_BITS     = 258,
  parameter int                         N_ENTRIES       = 512,
  parameter int                         TMO_CYCLES      = 1024,
  parameter bit                         AUTO_ACK        = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [3:0]                    req_op,
  input  logic [$clog2(N_ENTRIES)-1:0]  req_addr,
  input  logic [N_DATA_BITS-1:0]        req_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [2:0]                    rsp_code,
  output logic [N_DATA_BITS-1:0]        rsp_data,
  output logic                          rsp_local_tmo,
  output logic [N_REG_ADDR_BITS-1:0]    reg_addr,
  output logic                          wr_stb,
  output logic [N_DATA_BITS-1:0]        wr_dat,
  output logic [3:0]                    cmnd_op,
  output logic [$clog2(N_ENTRIES)-1:0]  cmnd_addr,
  input  logic [2:0]                    stat_code,
  input  logic [N_DATA_BITS-1:0]        rd_dat,
  output logic                          busy
);

  localparam int AW = $clog2(N_ENTRIES);

  initiator_state_t state, state_nxt;

  logic                   armed_q;
  logic [3:0]             op_q;
  logic [AW-1:0]          addr_q;
  logic [N_DATA_BITS-1:0] data_q;
  logic [2:0]             rsp_code_q;
  logic [N_DATA_BITS-1:0] rsp_data_q;
  logic                   rsp_tmo_q;

  logic tmr_clear;
  logic tmr_enable;
  logic tmr_expired;
  logic stat_done;
  logic op_returns_data;
  logic req_fire;

  assign stat_done       = stat_is_done(stat_code);
  assign op_returns_data = (op_q == OP_READ) || (op_q == OP_COMPARE);
  assign req_fire        = (state == S_IDLE) && armed_q && req_valid;

  nx_indirect_poll_timer #(
    .TMO_CYCLES (TMO_CYCLES)
  ) u_poll_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expired (tmr_expired)
  );

  // armed_q keeps req_ready low for the first cycle after reset releases.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      armed_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    wr_stb     = 1'b0;
    reg_addr   = '0;
    cmnd_op    = '0;
    cmnd_addr  = '0;
    wr_dat     = '0;
    tmr_clear  = 1'b0;
    tmr_enable = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = armed_q;
        if (req_fire) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        wr_stb    = 1'b1;
        reg_addr  = CMND_ADDRESS;
        cmnd_op   = op_q;
        cmnd_addr = addr_q;
        wr_dat    = data_q;
        tmr_clear = 1'b1;
        state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        state_nxt = S_POLL;
      end
      S_POLL: begin
        tmr_enable = 1'b1;
        if (stat_done || tmr_expired) state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = (AUTO_ACK && (rsp_code_q != ST_OK)) ? S_ACK : S_IDLE;
        end
      end
      S_ACK: begin
        wr_stb    = 1'b1;
        reg_addr  = CMND_ADDRESS;
        cmnd_op   = OP_ACK_ERROR;
        tmr_clear = 1'b1;
        state_nxt = S_SETTLE_ACK;
      end
      S_SETTLE_ACK: begin
        state_nxt = S_ACK_POLL;
      end
      S_ACK_POLL: begin
        tmr_enable = 1'b1;
        if ((stat_code == ST_EMPTY) || tmr_expired) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // A genuine completion wins over a timer expiring in the same poll cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rsp_code_q <= '0;
      rsp_data_q <= '0;
      rsp_tmo_q  <= 1'b0;
    end else begin
      if (req_fire) begin
        op_q   <= req_op;
        addr_q <= req_addr;
        data_q <= req_data;
      end
      if (state == S_POLL) begin
        if (stat_done) begin
          rsp_code_q <= stat_code;
          rsp_data_q <= op_returns_data ? rd_dat : '0;
          rsp_tmo_q  <= 1'b0;
        end else if (tmr_expired) begin
          rsp_code_q <= ST_TIMEOUT;
          rsp_data_q <= '0;
          rsp_tmo_q  <= 1'b1;
        end
      end
    end
  end

  assign rsp_code      = (state == S_RESP) ? rsp_code_q : '0;
  assign rsp_data      = (state == S_RESP) ? rsp_data_q : '0;
  assign rsp_local_tmo = (state == S_RESP) ? rsp_tmo_q  : 1'b0;
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_nx_indirect_access_initiator.sv
// Self-checking bench: table of directed and random transactions against a
// scripted responder and a cycle-count reference model.
module tb_nx_indirect_access_initiator;
  import nx_mem_typePKG::*;

  localparam int          DW   = 258;
  localparam int          AW   = 9;
  localparam int          TMO  = 16;
  localparam logic [15:0] CMND = 16'h0040;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [2:0]    rsp_code;
  logic [DW-1:0] rsp_data;
  logic          rsp_local_tmo;
  logic [15:0]   reg_addr;
  logic          wr_stb;
  logic [DW-1:0] wr_dat;
  logic [3:0]    cmnd_op;
  logic [AW-1:0] cmnd_addr;
  logic [2:0]    stat_code;
  logic [DW-1:0] rd_dat;
  logic          busy;

  always #5 clk = ~clk;

  nx_indirect_access_initiator #(
    .N_REG_ADDR_BITS (16),
    .CMND_ADDRESS    (CMND),
    .N_DATA_BITS     (DW),
    .N_ENTRIES       (512),
    .TMO_CYCLES      (TMO),
    .AUTO_ACK        (1'b1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_code      (rsp_code),
    .rsp_data      (rsp_data),
    .rsp_local_tmo (rsp_local_tmo),
    .reg_addr      (reg_addr),
    .wr_stb        (wr_stb),
    .wr_dat        (wr_dat),
    .cmnd_op       (cmnd_op),
    .cmnd_addr     (cmnd_addr),
    .stat_code     (stat_code),
    .rd_dat        (rd_dat),
    .busy          (busy)
  );

  typedef struct {
    logic [3:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            busy;
    logic [2:0]    fin;
    logic [DW-1:0] rdat;
    int            ack_busy;
    int            hold;
    logic [2:0]    exp_code;
    logic          exp_tmo;
    logic [DW-1:0] exp_data;
    int            exp_lat;
    int            exp_ready_lat;
    int            exp_strobes;
  } vec_t;

  typedef struct {
    logic [15:0]   ra;
    logic [3:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } stb_t;

  int total = 0;
  int bad   = 0;
  int idle_leak = 0;
  stb_t stb_log[$];
  vec_t vecs[$];

  int            cfg_busy;
  int            cfg_ack_busy;
  logic [2:0]    cfg_final;
  logic [DW-1:0] cfg_rdat;

  logic [3:0] legal_ops [10] = '{OP_NOP, OP_READ, OP_WRITE, OP_ENABLE, OP_DISABLE,
                                 OP_RESET, OP_INIT, OP_INIT_INC, OP_SET_INIT_START, OP_COMPARE};
  logic [2:0] done_codes [4] = '{ST_OK, ST_KEY_ERROR, ST_TIMEOUT, ST_NAK};

  // Responder: after a strobe it leaves the old status up for one cycle, shows
  // BUSY for the configured number of poll cycles, then the final code.
  int         rsp_wait = 0;
  bit         rsp_active = 1'b0;
  bit         rsp_upd_rd = 1'b0;
  logic [2:0] rsp_fin = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      rsp_active <= 1'b0;
      stat_code  <= ST_EMPTY;
      rd_dat     <= '0;
    end else if (wr_stb) begin
      stb_log.push_back('{reg_addr, cmnd_op, cmnd_addr, wr_dat});
      rsp_active <= 1'b1;
      if (cmnd_op == OP_ACK_ERROR) begin
        rsp_wait   <= cfg_ack_busy;
        rsp_fin    <= ST_EMPTY;
        rsp_upd_rd <= 1'b0;
      end else begin
        rsp_wait   <= cfg_busy;
        rsp_fin    <= cfg_final;
        rsp_upd_rd <= 1'b1;
      end
    end else if (rsp_active) begin
      if (rsp_wait > 0) begin
        stat_code <= ST_BUSY;
        rsp_wait  <= rsp_wait - 1;
      end else begin
        stat_code  <= rsp_fin;
        if (rsp_upd_rd) rd_dat <= cfg_rdat;
        rsp_active <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && !wr_stb && (cmnd_op != '0 || cmnd_addr != '0 || wr_dat != '0))
      idle_leak <= idle_leak + 1;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom();
    w[DW-1:DW-2] = 2'($urandom());
    return w;
  endfunction

  // Reference model: completion arrives on poll cycle 'busy' unless the
  // TMO-cycle poll window runs out first; errors add an ACK exchange.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    bit   timed_out;
    bit   err;
    int   ack_wait;
    r = v;
    timed_out = (v.busy >= TMO);
    r.exp_tmo  = timed_out;
    r.exp_code = timed_out ? 3'(ST_TIMEOUT) : v.fin;
    r.exp_data = (!timed_out && (v.op == OP_READ || v.op == OP_COMPARE)) ? v.rdat : '0;
    r.exp_lat  = timed_out ? (TMO + 3) : (v.busy + 4);
    err = (r.exp_code != ST_OK);
    ack_wait = (v.ack_busy < TMO - 1) ? v.ack_busy : (TMO - 1);
    r.exp_ready_lat = err ? (ack_wait + 3) : 0;
    r.exp_strobes   = err ? 2 : 1;
    return r;
  endfunction

  function automatic vec_t mk(input logic [3:0] op, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data, input int bsy, input logic [2:0] fin,
                              input logic [DW-1:0] rdat, input int ack, input int hold,
                              input logic [2:0] code, input logic tmo, input logic [DW-1:0] edata,
                              input int lat, input int rlat, input int nstb);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.busy = bsy; v.fin = fin;
    v.rdat = rdat; v.ack_busy = ack; v.hold = hold;
    v.exp_code = code; v.exp_tmo = tmo; v.exp_data = edata;
    v.exp_lat = lat; v.exp_ready_lat = rlat; v.exp_strobes = nstb;
    return v;
  endfunction

  task automatic waitReady();
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("req_ready_idle", DW'(req_ready), DW'(1));
  endtask

  task automatic applyStimulus(input vec_t v);
    int n;
    int base;
    bit gap;
    cfg_busy = v.busy; cfg_final = v.fin; cfg_rdat = v.rdat; cfg_ack_busy = v.ack_busy;
    base = stb_log.size();
    waitReady();
    req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_data = v.data;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 4'($urandom()); req_addr = AW'($urandom()); req_data = rand_word();
    n = 1;
    while (!rsp_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("rsp_latency", DW'(n), DW'(v.exp_lat));
    checkOutput("rsp_code", DW'(rsp_code), DW'(v.exp_code));
    checkOutput("rsp_local_tmo", DW'(rsp_local_tmo), DW'(v.exp_tmo));
    checkOutput("rsp_data", rsp_data, v.exp_data);
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk); #1;
      checkOutput("rsp_hold", DW'(rsp_valid && !req_ready && rsp_code == v.exp_code &&
                                  rsp_data == v.exp_data), DW'(1));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput("rsp_valid_drop", DW'(rsp_valid), DW'(0));
    n = 0; gap = 1'b0;
    while (!req_ready && n < 100) begin
      if (!busy) gap = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    checkOutput("ready_latency", DW'(n), DW'(v.exp_ready_lat));
    checkOutput("busy_until_idle", DW'(gap), DW'(0));
    checkOutput("strobe_count", DW'(stb_log.size() - base), DW'(v.exp_strobes));
    if (stb_log.size() > base) begin
      checkOutput("cmd_reg_addr", DW'(stb_log[base].ra), DW'(CMND));
      checkOutput("cmd_op", DW'(stb_log[base].op), DW'(v.op));
      checkOutput("cmd_addr", DW'(stb_log[base].addr), DW'(v.addr));
      checkOutput("cmd_data", stb_log[base].data, v.data);
    end
    if (v.exp_strobes == 2 && stb_log.size() > base + 1) begin
      checkOutput("ack_reg_addr", DW'(stb_log[base+1].ra), DW'(CMND));
      checkOutput("ack_op", DW'(stb_log[base+1].op), DW'(OP_ACK_ERROR));
      checkOutput("ack_addr_data", DW'(stb_log[base+1].addr) | stb_log[base+1].data, DW'(0));
    end
  endtask

  function automatic logic [DW-1:0] all_outputs_or();
    return DW'(req_ready) | DW'(rsp_valid) | DW'(rsp_code) | rsp_data | DW'(rsp_local_tmo) |
           DW'(reg_addr) | DW'(wr_stb) | wr_dat | DW'(cmnd_op) | DW'(cmnd_addr) | DW'(busy);
  endfunction

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_addr = '0; req_data = '0;
    cfg_busy = 0; cfg_ack_busy = 0; cfg_final = ST_OK; cfg_rdat = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs_zero", all_outputs_or(), DW'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready_after_reset", DW'(req_ready), DW'(1));

    vecs.push_back(mk(OP_WRITE, 9'h1A5, {2'b11, {32{8'hA5}}}, 3, ST_OK, 258'h1234_5678, 0, 0,
                      ST_OK, 1'b0, '0, 7, 0, 1));
    vecs.push_back(mk(OP_READ, 9'h003, rand_word(), 0, ST_OK, 258'h3_DEAD, 0, 5,
                      ST_OK, 1'b0, 258'h3_DEAD, 4, 0, 1));
    vecs.push_back(mk(OP_WRITE, 9'h0FF, rand_word(), 2, ST_OK, 258'h9999, 0, 0,
                      ST_OK, 1'b0, '0, 6, 0, 1));
    vecs.push_back(mk(OP_COMPARE, 9'h010, rand_word(), 1, ST_KEY_ERROR, 258'h55AA, 2, 1,
                      ST_KEY_ERROR, 1'b0, 258'h55AA, 5, 5, 2));
    vecs.push_back(mk(OP_INIT, 9'h000, rand_word(), 100, ST_OK, 258'h1, 100, 0,
                      ST_TIMEOUT, 1'b1, '0, 19, 18, 2));
    vecs.push_back(mk(OP_READ, 9'h1FF, rand_word(), 15, ST_OK, 258'hBEEF, 0, 0,
                      ST_OK, 1'b0, 258'hBEEF, 19, 0, 1));
    vecs.push_back(mk(OP_WRITE, 9'h020, rand_word(), 16, ST_OK, 258'h2, 0, 0,
                      ST_TIMEOUT, 1'b1, '0, 19, 3, 2));
    vecs.push_back(mk(OP_DISABLE, 9'h044, rand_word(), 0, ST_NAK, 258'h3, 0, 0,
                      ST_NAK, 1'b0, '0, 4, 3, 2));
    vecs.push_back(mk(OP_ENABLE, 9'h045, rand_word(), 1, ST_TIMEOUT, 258'h4, 1, 0,
                      ST_TIMEOUT, 1'b0, '0, 5, 4, 2));
    vecs.push_back(mk(OP_NOP, 9'h000, '0, 0, ST_OK, 258'h5, 0, 0,
                      ST_OK, 1'b0, '0, 4, 0, 1));
    vecs.push_back(mk(OP_READ, 9'h077, rand_word(), 4, ST_NAK, 258'h77, 15, 0,
                      ST_NAK, 1'b0, 258'h77, 8, 18, 2));
    for (int r = 0; r < 12; r++) begin
      vec_t v;
      v.op       = legal_ops[$urandom_range(0, 9)];
      v.addr     = AW'($urandom());
      v.data     = rand_word();
      v.busy     = $urandom_range(0, 20);
      v.fin      = done_codes[$urandom_range(0, 3)];
      v.rdat     = rand_word();
      v.ack_busy = $urandom_range(0, 20);
      v.hold     = $urandom_range(0, 3);
      vecs.push_back(model(v));
    end

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // Reset while polling a stuck responder: the command is abandoned silently.
    cfg_busy = 100; cfg_final = ST_OK; cfg_ack_busy = 0; cfg_rdat = '0;
    waitReady();
    req_valid = 1'b1; req_op = OP_READ; req_addr = 9'h055; req_data = rand_word();
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("busy_before_reset", DW'(busy), DW'(1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("midop_reset_zero", all_outputs_or(), DW'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready_after_midop_reset", DW'(req_ready), DW'(1));
    n = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (rsp_valid || busy) n++;
    end
    checkOutput("no_rsp_after_reset", DW'(n), DW'(0));
    applyStimulus(mk(OP_READ, 9'h0AB, rand_word(), 1, ST_OK, 258'hC0FFEE, 0, 0,
                     ST_OK, 1'b0, 258'hC0FFEE, 5, 0, 1));

    checkOutput("idle_cmd_zero", DW'(idle_leak), DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
